// File: rtl/video_capture.sv
`default_nettype none
// ============================================================================
// Module   : video_capture
// Purpose  : Oric RGB/SYNC front-end: sync separation, 6 MHz pixel recovery,
//            pixel-pair packing and frame-buffer write requests.
// Options  : TEST_PATTERN_EN - TPAT=1 substitutes 8 colour bars for RGB.
// Revision : 1.0 - initial release
// ============================================================================
module video_capture #(
    parameter int H_START   = 7,
    parameter int H_PIXELS  = 240,
    parameter int V_START   = 40,
    parameter int V_LINES   = 224,
    parameter int VSYNC_MIN = 864
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        RED,
    input  logic        GREEN,
    input  logic        BLUE,
    input  logic        SYNC,
    input  logic        TPAT,
    output logic        WR_REQ,
    output logic [14:0] WR_ADDR,
    output logic [7:0]  WR_DATA,
    input  logic        WR_ACK,
    output logic        FIELD_START,
    output logic        LOCKED,
    output logic        OVERRUN
);

    localparam logic [1:0]  c_ST_IDLE   = 2'd0;
    localparam logic [1:0]  c_ST_DELAY  = 2'd1;
    localparam logic [1:0]  c_ST_SAMPLE = 2'd2;

    // DELAY burns H_START-3 clocks; the rise-detect and the SAMPLE entry cycle
    // account for the rest, so H_START must be at least 3.
    localparam logic [7:0]  c_DLY_INIT  = 8'(H_START - 3);
    localparam logic [8:0]  c_LAST_PIX  = 9'(H_PIXELS - 1);
    localparam logic [14:0] c_HALF_LINE = 15'(H_PIXELS / 2);
    localparam logic [8:0]  c_V_START   = 9'(V_START);
    localparam logic [9:0]  c_V_END     = 10'(V_START + V_LINES);
    localparam logic [11:0] c_VSYNC_MIN = 12'(VSYNC_MIN);

    logic [1:0]  r_red_sync;
    logic [1:0]  r_green_sync;
    logic [1:0]  r_blue_sync;
    logic [1:0]  r_sync_sync;
    logic [1:0]  r_sync_hist;
    logic        r_fsync;
    logic        r_fsync_d;
    logic        w_rise;
    logic        w_fall;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_red_sync   <= '0;
            r_green_sync <= '0;
            r_blue_sync  <= '0;
            r_sync_sync  <= 2'b11;
            r_sync_hist  <= 2'b11;
            r_fsync      <= 1'b1;
            r_fsync_d    <= 1'b1;
        end else begin
            r_red_sync   <= {r_red_sync[0], RED};
            r_green_sync <= {r_green_sync[0], GREEN};
            r_blue_sync  <= {r_blue_sync[0], BLUE};
            r_sync_sync  <= {r_sync_sync[0], SYNC};
            r_sync_hist  <= {r_sync_hist[0], r_sync_sync[1]};
            // Three agreeing samples are needed before fsync follows the pin
            if ((r_sync_sync[1] == r_sync_hist[0]) && (r_sync_sync[1] == r_sync_hist[1]))
                r_fsync <= r_sync_sync[1];
            r_fsync_d    <= r_fsync;
        end
    end

    assign w_rise = r_fsync & ~r_fsync_d;
    assign w_fall = ~r_fsync & r_fsync_d;

    logic [11:0] r_low_cnt;
    logic [8:0]  r_line_cnt;
    logic [14:0] r_line_base;
    logic        r_base_pend;
    logic        r_locked;
    logic        r_field_start;
    logic        w_is_vsync;
    logic [8:0]  w_line_next;
    logic        w_locked_next;
    logic [14:0] w_base_next;
    logic        w_line_active;

    assign w_is_vsync = (r_low_cnt >= c_VSYNC_MIN);

    always_comb begin
        w_line_next   = r_line_cnt;
        w_locked_next = r_locked;
        w_base_next   = r_line_base;
        if (w_is_vsync) begin
            w_line_next   = '0;
            w_locked_next = 1'b1;
            w_base_next   = '0;
        end else begin
            if (r_line_cnt != 9'd511)
                w_line_next = r_line_cnt + 9'd1;
            if (w_line_next == 9'd511)
                w_locked_next = 1'b0;
            // The previous captured line always consumes a full line of
            // addresses, even if it was cut short.
            if (r_base_pend)
                w_base_next = r_line_base + c_HALF_LINE;
        end
        w_line_active = w_locked_next && (w_line_next >= c_V_START) &&
                        ({1'b0, w_line_next} < c_V_END);
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_low_cnt     <= '0;
            r_line_cnt    <= '0;
            r_line_base   <= '0;
            r_base_pend   <= 1'b0;
            r_locked      <= 1'b0;
            r_field_start <= 1'b0;
        end else begin
            r_field_start <= w_rise & w_is_vsync;
            if (w_rise) begin
                r_low_cnt   <= '0;
                r_line_cnt  <= w_line_next;
                r_line_base <= w_base_next;
                r_base_pend <= w_line_active;
                r_locked    <= w_locked_next;
            end else if (!r_fsync && (r_low_cnt != 12'hFFF)) begin
                r_low_cnt <= r_low_cnt + 12'd1;
            end
        end
    end

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [8:0]  r_pix;
    logic [8:0]  w_pix_next;
    logic        w_sample;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_pix   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pix   <= w_pix_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pix_next   = r_pix;
        w_sample     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rise && w_line_active) begin
                    w_state_next = c_ST_DELAY;
                    w_cnt_next   = c_DLY_INIT;
                    w_pix_next   = '0;
                end
            end
            c_ST_DELAY: begin
                if (w_fall) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_cnt == 8'd0) begin
                    w_state_next = c_ST_SAMPLE;
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            c_ST_SAMPLE: begin
                if (w_fall) begin
                    w_state_next = c_ST_IDLE;
                end else if (r_cnt == 8'd0) begin
                    w_sample = 1'b1;
                    if (r_pix == c_LAST_PIX) begin
                        w_state_next = c_ST_IDLE;
                    end else begin
                        w_pix_next = r_pix + 9'd1;
                        // 4 then 5 clocks: 9 clocks per pair at 27 MHz = 6 MHz
                        w_cnt_next = r_pix[0] ? 8'd4 : 8'd3;
                    end
                end else begin
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    logic [14:0] r_line_addr;
    logic [2:0]  r_even_rgb;
    logic [2:0]  w_cam_rgb;
    logic [2:0]  w_pix_rgb;
    logic        w_push;
    logic [14:0] w_push_addr;
    logic [7:0]  w_push_data;

    assign w_cam_rgb = {r_red_sync[1], r_green_sync[1], r_blue_sync[1]};

`ifdef TEST_PATTERN_EN
    assign w_pix_rgb = TPAT ? r_pix[7:5] : w_cam_rgb;
`else
    logic w_unused_tpat;
    assign w_unused_tpat = TPAT;
    assign w_pix_rgb     = w_cam_rgb;
`endif

    assign w_push      = w_sample & r_pix[0];
    assign w_push_addr = r_line_addr + {7'd0, r_pix[8:1]};
    assign w_push_data = {1'b0, r_even_rgb, 1'b0, w_pix_rgb};

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            r_line_addr <= '0;
            r_even_rgb  <= '0;
        end else begin
            if (w_rise && w_line_active && (r_state == c_ST_IDLE))
                r_line_addr <= w_base_next;
            if (w_sample && !r_pix[0])
                r_even_rgb <= w_pix_rgb;
        end
    end

    logic [14:0] r_fifo_addr [2];
    logic [7:0]  r_fifo_data [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;
    logic        r_overrun;
    logic        w_pop;
    logic        w_full;
    logic        w_push_ok;

    assign WR_REQ    = (r_count != 2'd0);
    assign w_pop     = WR_REQ & WR_ACK;
    assign w_full    = (r_count == 2'd2);
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
            end
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_fifo_addr[r_wr_ptr] <= w_push_addr;
                r_fifo_data[r_wr_ptr] <= w_push_data;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop)
                r_overrun <= 1'b1;
        end
    end

    assign WR_ADDR     = WR_REQ ? r_fifo_addr[r_rd_ptr] : 15'd0;
    assign WR_DATA     = WR_REQ ? r_fifo_data[r_rd_ptr] : 8'd0;
    assign FIELD_START = r_field_start;
    assign LOCKED      = r_locked;
    assign OVERRUN     = r_overrun;

endmodule
`default_nettype wire
